// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cond_pkg
//  Purpose  : Shared types for the execute-stage condition logic. Contains the
//             ARM condition-code encoding, the NZCV flag bit positions, the IT
//             sequencer state encoding, and a helper that builds the "else"
//             form of an IT base condition.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cond_pkg;

    // ARM condition field encoding. NV (1111) is never taken.
    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    // Bit positions inside the 4-bit {N,Z,C,V} flag vector
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    typedef enum logic [0:0] {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_state_e;

    // The "else" condition of an IT slot is the base condition with its LSB
    // flipped, which yields the logical complement for every pair EQ/NE ...
    // Note that AL becomes NV, so an "else" slot of an AL block is annulled.
    function automatic cond_e it_else_cond(input cond_e base);
        logic [3:0] raw;
        raw = base;
        return cond_e'({raw[3:1], ~raw[0]});
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : cond_eval
//  Purpose  : Combinational evaluation of an ARM condition code against the
//             NZCV flags. Shared with the branch predictor checker.
//  Ports    : cond  in  4  condition code (cond_e)
//             flags in  4  {N,Z,C,V}
//             pass  out 1  condition holds
//  Revision : 1.0  initial release
// ============================================================================
module cond_eval
    import cond_pkg::*;
(
    input  cond_e       cond,
    input  logic [3:0]  flags,
    output logic        pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags[N];
    assign w_z = flags[Z];
    assign w_c = flags[C];
    assign w_v = flags[V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ:      pass = w_z;
            NE:      pass = ~w_z;
            CS:      pass = w_c;
            CC:      pass = ~w_c;
            MI:      pass = w_n;
            PL:      pass = ~w_n;
            VS:      pass = w_v;
            VC:      pass = ~w_v;
            HI:      pass = w_c & ~w_z;
            LS:      pass = ~w_c | w_z;
            GE:      pass = (w_n == w_v);
            LT:      pass = (w_n != w_v);
            GT:      pass = ~w_z & (w_n == w_v);
            LE:      pass = w_z | (w_n != w_v);
            AL:      pass = 1'b1;
            default: pass = 1'b0;   // NV
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit_pipe
//  Purpose  : Execute-stage condition unit. Holds NZCV, evaluates the
//             instruction (or IT-slot) condition, gates the write strobes
//             into the E->M register, sequences Thumb-style IT blocks and
//             counts annulled instructions (saturating).
//  Ports    : clk, reset            clock, synchronous active-high reset
//             validE/stallE/flushE  E-stage qualifiers
//             CondE[3:0]            instruction condition
//             FlagWriteE[1:0]       [1]=NZ write, [0]=CV write
//             ALUFlagsE[3:0]        {N,Z,C,V} from the ALU
//             CtrlE[N_CTRL-1:0]     ungated write strobes
//             PCSrcE, BranchE       PC-write sources
//             ItStartE/ItCondE/ItLenE/ItTeE  IT instruction fields
//             CondExE               condition passed (combinational)
//             FlagsQ[3:0]           flag register
//             CtrlM, PCSrcM         gated strobes / PC select, registered
//             ItActive              IT block in progress
//             AnnulCnt[CNT_W-1:0]   annulled-instruction count
//  Revision : 1.0  initial release
// ============================================================================
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter int N_CTRL   = 2,
    parameter int IT_EN    = 1,
    parameter int IT_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validE,
    input  logic              stallE,
    input  logic              flushE,
    input  logic [3:0]        CondE,
    input  logic [1:0]        FlagWriteE,
    input  logic [3:0]        ALUFlagsE,
    input  logic [N_CTRL-1:0] CtrlE,
    input  logic              PCSrcE,
    input  logic              BranchE,
    input  logic              ItStartE,
    input  logic [3:0]        ItCondE,
    input  logic [1:0]        ItLenE,
    input  logic [2:0]        ItTeE,
    output logic              CondExE,
    output logic [3:0]        FlagsQ,
    output logic [N_CTRL-1:0] CtrlM,
    output logic              PCSrcM,
    output logic              ItActive,
    output logic [CNT_W-1:0]  AnnulCnt
);

    logic              w_adv;
    logic              w_it_active;
    cond_e             w_slot_cond;
    cond_e             w_eff_cond;
    logic              w_pass;

    logic [3:0]        r_flags;
    logic [N_CTRL-1:0] r_ctrl_m;
    logic              r_pcsrc_m;
    logic [CNT_W-1:0]  r_annul;

    // An instruction "advances" only when it is real, not held and not killed
    assign w_adv = validE & ~stallE & ~flushE;

    // ------------------------------------------------------------------
    // IT sequencer
    // ------------------------------------------------------------------
    generate
        if (IT_EN != 0) begin : g_it_seq
            localparam logic [2:0] c_it_depth = 3'(IT_DEPTH);

            it_state_e  r_it_state;
            cond_e      r_it_base;
            logic [2:0] r_it_rem;     // slots still to be consumed
            logic [3:0] r_it_mask;    // bit0 = then(1)/else(0) of current slot
            logic [2:0] w_len_req;
            logic [2:0] w_len_clamped;

            assign w_len_req     = {1'b0, ItLenE} + 3'd1;
            assign w_len_clamped = (w_len_req > c_it_depth) ? c_it_depth : w_len_req;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_it_state <= IT_IDLE;
                    r_it_base  <= AL;
                    r_it_rem   <= 3'd0;
                    r_it_mask  <= 4'd0;
                end else if (flushE) begin
                    r_it_state <= IT_IDLE;
                end else if (w_adv) begin
                    if (ItStartE) begin
                        // A new IT (also mid-block) restarts the sequence;
                        // slot 1 is always "then".
                        r_it_state <= IT_ACTIVE;
                        r_it_base  <= cond_e'(ItCondE);
                        r_it_rem   <= w_len_clamped;
                        r_it_mask  <= {ItTeE, 1'b1};
                    end else if (r_it_state == IT_ACTIVE) begin
                        r_it_mask <= {1'b0, r_it_mask[3:1]};
                        r_it_rem  <= r_it_rem - 3'd1;
                        if (r_it_rem <= 3'd1) begin
                            r_it_state <= IT_IDLE;
                        end
                    end
                end
            end

            assign w_it_active = (r_it_state == IT_ACTIVE);
            assign w_slot_cond = r_it_mask[0] ? r_it_base : it_else_cond(r_it_base);
        end else begin : g_it_off
            logic w_it_unused;
            assign w_it_unused = ^{ItStartE, ItCondE, ItLenE, ItTeE};
            assign w_it_active = 1'b0;
            assign w_slot_cond = AL;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Condition evaluation (no forwarding: uses the registered flags)
    // ------------------------------------------------------------------
    assign w_eff_cond = w_it_active ? w_slot_cond : cond_e'(CondE);

    cond_eval u_cond_eval (
        .cond  (w_eff_cond),
        .flags (r_flags),
        .pass  (w_pass)
    );

    assign CondExE = validE & ~flushE & w_pass;

    // ------------------------------------------------------------------
    // Flags, E->M register, annul counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags   <= 4'd0;
            r_ctrl_m  <= '0;
            r_pcsrc_m <= 1'b0;
            r_annul   <= '0;
        end else begin
            if (w_adv & CondExE) begin
                if (FlagWriteE[1]) r_flags[N:Z] <= ALUFlagsE[N:Z];
                if (FlagWriteE[0]) r_flags[C:V] <= ALUFlagsE[C:V];
            end

            // Non-advancing cycles insert a bubble into M
            if (w_adv) begin
                r_ctrl_m  <= CtrlE & {N_CTRL{CondExE}};
                r_pcsrc_m <= CondExE & (PCSrcE | BranchE);
            end else begin
                r_ctrl_m  <= '0;
                r_pcsrc_m <= 1'b0;
            end

            if (w_adv & ~CondExE & ~(&r_annul)) begin
                r_annul <= r_annul + 1'b1;
            end
        end
    end

    assign FlagsQ   = r_flags;
    assign CtrlM    = r_ctrl_m;
    assign PCSrcM   = r_pcsrc_m;
    assign ItActive = w_it_active;
    assign AnnulCnt = r_annul;

endmodule
`default_nettype wire

// File: doc/cond_unit_pipe.md
Name: cond_unit_pipe

Overview:
Parametrised execute-stage condition unit for the pipelined ARM-style core.
- Holds the architectural NZCV flags and evaluates the instruction condition.
- Gates N_CTRL write strobes and registers them into the E->M boundary.
- Adds stall, flush and valid handling, a Thumb-style IT-block sequencer (up to IT_DEPTH conditional slots), and a saturating annulled-instruction counter.

Parameters:
N_CTRL, 2, number of gated write strobes (bit0 RegWrite, bit1 MemWrite, extra bits user-defined)
IT_EN, 1, 1 = IT sequencer present; 0 = IT inputs ignored, ItActive tied 0
IT_DEPTH, 4, maximum IT block length (1..4)
CNT_W, 16, width of annul counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
validE  in  1  E stage holds a real instruction
stallE  in  1  E stage held this cycle
flushE  in  1  kill instruction in E
CondE  in  4  instruction condition field
FlagWriteE  in  2  [1]=NZ write, [0]=CV write
ALUFlagsE  in  4  {N,Z,C,V} from ALU
CtrlE  in  N_CTRL  ungated write strobes
PCSrcE  in  1  PC write by data-processing instruction
BranchE  in  1  branch instruction
ItStartE  in  1  E instruction is IT
ItCondE  in  4  IT firstcond
ItLenE  in  2  block length minus 1
ItTeE  in  3  then(1)/else(0) for slots 2..4, bit0 = slot 2
CondExE  out  1  condition passed, combinational
FlagsQ  out  4  current flag register
CtrlM  out  N_CTRL  gated strobes, registered
PCSrcM  out  1  gated PC select, registered
ItActive  out  1  IT block in progress
AnnulCnt  out  CNT_W  annulled-instruction count

Behaviour:
- Reset: FlagsQ=0, CtrlM=0, PCSrcM=0, ItActive=0, AnnulCnt=0, IT state IDLE.
- Advance condition: adv = validE & ~stallE & ~flushE.
- Effective condition:
  - When ItActive, the IT slot condition: base cond for "then", base cond with LSB inverted for "else".
  - Otherwise CondE.
- Condition evaluation: standard 0000..1110 decode (EQ..AL). 1111 evaluates false; an instruction with it is annulled.
- CondExE = validE & ~flushE & eval(effective cond, FlagsQ). Combinational; no flag forwarding. Flags written in cycle t are visible to the instruction in E at t+1.
- Flags:
  - NZ loads ALUFlagsE[3:2] when adv & CondExE & FlagWriteE[1].
  - CV loads ALUFlagsE[1:0] when adv & CondExE & FlagWriteE[0].
- M register, 1-cycle latency, updated every cycle:
  - If adv: CtrlM <= CtrlE & {N_CTRL{CondExE}}; PCSrcM <= CondExE & (PCSrcE | BranchE).
  - Else (stall, flush or invalid): CtrlM <= 0, PCSrcM <= 0 (bubble).
- IT state machine, IDLE / ACTIVE, with slot counter and then/else shift register:
  - IDLE->ACTIVE: adv & ItStartE. Load base = ItCondE, remaining = ItLenE+1, clamped to IT_DEPTH. The IT instruction itself executes unconditionally with respect to the block.
  - ACTIVE: each adv instruction consumes one slot, whether it passes or fails. Slot 1 uses "then"; slot k uses ItTeE[k-2].
  - ACTIVE->IDLE: when the last slot is consumed.
  - Stall or invalid cycles consume no slot.
  - ItStartE on an adv instruction while ACTIVE consumes the current slot and restarts the block with the new parameters.
  - flushE forces IDLE next cycle.
  - IT_EN=0: state stays IDLE.
- AnnulCnt increments by 1 when validE & ~stallE & ~flushE & ~CondExE. It saturates at all-ones.
- Reset asserted mid-block clears all state on the next edge.

Decomposition:
- Package cond_pkg holds:
  - cond_e enum (EQ..AL, NV = 4'b1111)
  - flag index localparams N=3, Z=2, C=1, V=0
  - it_state_e {IT_IDLE, IT_ACTIVE}
- Sub-module cond_eval: combinational, input cond_e + flags, output pass. It is reused by the branch predictor checker.

Test Plan:
- Reset, then CondE=EQ with FlagsQ=0 -> CondExE=0, CtrlM=0 next cycle, AnnulCnt=1.
- CMP (FlagWriteE=11, ALUFlagsE=0100, CondE=AL), then CondE=EQ with CtrlE=01 -> FlagsQ=0100; next cycle CtrlM=01.
- FlagWriteE=10 with ALUFlagsE=1011 from FlagsQ=0100 -> FlagsQ=1000 (CV preserved).
- BranchE=1, CondE=NE, Z=1 -> PCSrcM=0. Repeat with Z=0 -> PCSrcM=1.
- IT with ItCondE=EQ, ItLenE=2, ItTeE=010 and Z=1 -> slot CondExE sequence 1,0,1, then ItActive=0.
  - Same block with stallE asserted 2 cycles between slots -> identical sequence, no slot lost.
  - flushE during slot 2 -> ItActive=0 next cycle.
- stallE=1 with a passing instruction -> flags unchanged and CtrlM=0. Drive 2^CNT_W+3 annulled instructions -> AnnulCnt stays at all-ones.
